enemy_base_ctrl: RTL and testbench

ENEMY_BASE_CTRL -- requirements
Module: enemy_base_ctrl

---
 rtl/enemy_base_pkg.sv | 30 +++
 rtl/enemy_base_if.sv | 29 ++
 rtl/enemy_base_fsm.sv | 118 +++++++++++
 rtl/enemy_base_ctrl.sv | 92 +++++++++
 tb/tb_enemy_base_ctrl.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/enemy_base_pkg.sv
// enemy_base_pkg: shared constants, state type and helpers for the enemy base
// controller. Imported by enemy_base_if, enemy_base_fsm and enemy_base_ctrl.
package enemy_base_pkg;

  localparam int N_BASES        = 4;
  localparam int BASE_W         = 64;
  localparam int BASE_H         = 72;
  localparam int SCREEN_W       = 640;
  localparam int SCREEN_H       = 480;
  localparam int EXPLODE_FRAMES = 16;
  localparam int RESPAWN_FRAMES = 120;

  // Home corners, index 0 in the low slot.
  localparam logic [N_BASES-1:0][9:0] HOME_X = {10'd500, 10'd100, 10'd400, 10'd200};
  localparam logic [N_BASES-1:0][9:0] HOME_Y = {10'd80,  10'd350, 10'd300, 10'd100};

  typedef enum logic [1:0] {
    ST_ALIVE   = 2'd0,
    ST_EXPLODE = 2'd1,
    ST_DEAD    = 2'd2
  } base_state_t;

  function automatic logic [2:0] popcount(input logic [N_BASES-1:0] v);
    logic [2:0] c;
    c = '0;
    for (int i = 0; i < N_BASES; i++) c = c + 3'(v[i]);
    return c;
  endfunction

endpackage

// File: rtl/enemy_base_if.sv
// enemy_base_if: groups the scroll/hit/pixel inputs and the per-base position,
// status, draw and score outputs of enemy_base_ctrl.
//   master: bench/game side (drives direction, hit, DrawX, DrawY)
//   slave : enemy_base_ctrl (drives Base_X, Base_Y, alive, draw_*, score_inc)
interface enemy_base_if;
  import enemy_base_pkg::*;

  logic [3:0]                 direction;
  logic [N_BASES-1:0]         hit;
  logic [9:0]                 DrawX;
  logic [9:0]                 DrawY;
  logic [N_BASES-1:0][9:0]    Base_X;
  logic [N_BASES-1:0][9:0]    Base_Y;
  logic [N_BASES-1:0]         alive;
  logic                       draw_valid;
  logic [1:0]                 draw_sel;
  logic                       draw_explode;
  logic [2:0]                 score_inc;

  modport master (
    output direction, hit, DrawX, DrawY,
    input  Base_X, Base_Y, alive, draw_valid, draw_sel, draw_explode, score_inc
  );

  modport slave (
    input  direction, hit, DrawX, DrawY,
    output Base_X, Base_Y, alive, draw_valid, draw_sel, draw_explode, score_inc
  );
endinterface

// File: rtl/enemy_base_fsm.sv
// enemy_base_fsm: state, explode/respawn timers and scrolled position of one base.
// Ports: clk, rst (sync active-high), frame_evt_i (one-cycle frame event),
//        dir_i (one-hot scroll), hit_i, x_o/y_o (top-left corner), state_o.
// Optional feature: BASE_RESPAWN_EN adds a DEAD timer that returns the base home.
//
// state     | meaning
// ----------+---------------------------------------------------------
// S_ALIVE   | visible, scrolls, accepts hit
// S_EXPLODE | visible, scrolls, counts down EXPLODE_FRAMES frame events
// S_DEAD    | hidden, frozen; terminal unless respawn timer is built in
module enemy_base_fsm
  import enemy_base_pkg::*;
#(
  parameter logic [9:0] HOME_X_P = 10'd0,
  parameter logic [9:0] HOME_Y_P = 10'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_evt_i,
  input  logic [3:0]  dir_i,
  input  logic        hit_i,
  output logic [9:0]  x_o,
  output logic [9:0]  y_o,
  output base_state_t state_o
);

  localparam logic [1:0] S_ALIVE   = 2'd0;
  localparam logic [1:0] S_EXPLODE = 2'd1;
  localparam logic [1:0] S_DEAD    = 2'd2;
  localparam logic [9:0] X_MAX     = 10'(SCREEN_W - 1);
  localparam logic [9:0] Y_MAX     = 10'(SCREEN_H - 1);

  logic [1:0] state_q, state_d;
  logic [9:0] x_q, x_d, y_q, y_d;
  logic [4:0] expl_cnt_q, expl_cnt_d;
`ifdef BASE_RESPAWN_EN
  logic [6:0] resp_cnt_q, resp_cnt_d;
`endif

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    expl_cnt_d = expl_cnt_q;
`ifdef BASE_RESPAWN_EN
    resp_cnt_d = resp_cnt_q;
`endif

    // Movement and state change are independent so a hit on a frame event does both.
    if (frame_evt_i && (state_q != S_DEAD)) begin
      case (dir_i)
        4'b1000: y_d = (y_q == Y_MAX) ? 10'd0 : y_q + 10'd1;
        4'b0100: y_d = (y_q == 10'd0) ? Y_MAX : y_q - 10'd1;
        4'b0010: x_d = (x_q == 10'd0) ? X_MAX : x_q - 10'd1;
        4'b0001: x_d = (x_q == X_MAX) ? 10'd0 : x_q + 10'd1;
        default: ;
      endcase
    end

    case (state_q)
      S_ALIVE: begin
        if (hit_i) begin
          state_d    = S_EXPLODE;
          expl_cnt_d = 5'(EXPLODE_FRAMES);
        end
      end
      S_EXPLODE: begin
        if (frame_evt_i) begin
          expl_cnt_d = expl_cnt_q - 5'd1;
          if (expl_cnt_q == 5'd1) begin
            state_d = S_DEAD;
`ifdef BASE_RESPAWN_EN
            resp_cnt_d = 7'(RESPAWN_FRAMES);
`endif
          end
        end
      end
      S_DEAD: begin
`ifdef BASE_RESPAWN_EN
        if (frame_evt_i) begin
          resp_cnt_d = resp_cnt_q - 7'd1;
          if (resp_cnt_q == 7'd1) begin
            state_d = S_ALIVE;
            x_d     = HOME_X_P;
            y_d     = HOME_Y_P;
          end
        end
`endif
      end
      default: state_d = S_ALIVE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_ALIVE;
      x_q        <= HOME_X_P;
      y_q        <= HOME_Y_P;
      expl_cnt_q <= '0;
`ifdef BASE_RESPAWN_EN
      resp_cnt_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      expl_cnt_q <= expl_cnt_d;
`ifdef BASE_RESPAWN_EN
      resp_cnt_q <= resp_cnt_d;
`endif
    end
  end

  assign x_o     = x_q;
  assign y_o     = y_q;
  assign state_o = base_state_t'(state_q);

endmodule

// File: rtl/enemy_base_ctrl.sv
// enemy_base_ctrl: N_BASES enemy bases scrolling with the map, hit/explode/dead
// tracking, per-pixel draw arbitration and score increments.
// Ports: vga_clk (sole clock), Reset (sync active-high), frame_clk (frame tick
//        level), bus (enemy_base_if.slave: direction, hit, DrawX/DrawY in;
//        Base_X/Base_Y, alive, draw_valid, draw_sel, draw_explode, score_inc out).
// Optional feature: BASE_RESPAWN_EN (see enemy_base_fsm).
module enemy_base_ctrl
  import enemy_base_pkg::*;
(
  input  logic         vga_clk,
  input  logic         Reset,
  input  logic         frame_clk,
  enemy_base_if.slave  bus
);

  logic                    frame_q;
  logic                    frame_evt;
  logic [N_BASES-1:0][9:0] x_w, y_w, dx_w, dy_w;
  logic [N_BASES-1:0]      alive_w, explode_w, cover_w;
  logic                    valid_d, valid_q;
  logic [1:0]              sel_d, sel_q;
  logic                    expl_d, expl_q;
  logic [2:0]              score_q;

  assign frame_evt = frame_clk & ~frame_q;

  for (genvar g = 0; g < N_BASES; g++) begin : g_base
    base_state_t st;

    enemy_base_fsm #(
      .HOME_X_P (HOME_X[g]),
      .HOME_Y_P (HOME_Y[g])
    ) u_fsm (
      .clk         (vga_clk),
      .rst         (Reset),
      .frame_evt_i (frame_evt),
      .dir_i       (bus.direction),
      .hit_i       (bus.hit[g]),
      .x_o         (x_w[g]),
      .y_o         (y_w[g]),
      .state_o     (st)
    );

    assign alive_w[g]   = (st == ST_ALIVE);
    assign explode_w[g] = (st == ST_EXPLODE);
    // 10-bit differences wrap mod 1024, so a base near the right/bottom edge
    // still covers pixels past 639/479 without special casing.
    assign dx_w[g]      = bus.DrawX - x_w[g];
    assign dy_w[g]      = bus.DrawY - y_w[g];
    assign cover_w[g]   = (alive_w[g] | explode_w[g]) &&
                          (dx_w[g] < 10'(BASE_W)) && (dy_w[g] < 10'(BASE_H));
  end

  // Scan high to low so the lowest covering index wins.
  always_comb begin
    valid_d = 1'b0;
    sel_d   = '0;
    expl_d  = 1'b0;
    for (int i = N_BASES - 1; i >= 0; i--) begin
      if (cover_w[i]) begin
        valid_d = 1'b1;
        sel_d   = 2'(i);
        expl_d  = explode_w[i];
      end
    end
  end

  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      frame_q <= 1'b0;
      score_q <= '0;
      valid_q <= 1'b0;
      sel_q   <= '0;
      expl_q  <= 1'b0;
    end else begin
      frame_q <= frame_clk;
      score_q <= popcount(bus.hit & alive_w);
      valid_q <= valid_d;
      sel_q   <= sel_d;
      expl_q  <= expl_d;
    end
  end

  assign bus.Base_X       = x_w;
  assign bus.Base_Y       = y_w;
  assign bus.alive        = alive_w;
  assign bus.draw_valid   = valid_q;
  assign bus.draw_sel     = sel_q;
  assign bus.draw_explode = expl_q;
  assign bus.score_inc    = score_q;

endmodule

// File: tb/tb_enemy_base_ctrl.sv
module tb_enemy_base_ctrl;
  import enemy_base_pkg::*;

  logic vga_clk = 1'b0;
  logic Reset;
  logic frame_clk;
  int   n_assert = 0;
  int   n_fail   = 0;

  enemy_base_if bus();

  enemy_base_ctrl dut (
    .vga_clk   (vga_clk),
    .Reset     (Reset),
    .frame_clk (frame_clk),
    .bus       (bus)
  );

  always #5 vga_clk = ~vga_clk;

  task automatic tick();
    @(posedge vga_clk);
    #1;
  endtask

  task automatic frame_evts(input int n);
    for (int k = 0; k < n; k++) begin
      frame_clk = 1'b1;
      tick();
      frame_clk = 1'b0;
      tick();
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    Reset         = 1'b1;
    frame_clk     = 1'b0;
    bus.direction = 4'b0000;
    bus.hit       = '0;
    bus.DrawX     = 10'd210;
    bus.DrawY     = 10'd110;
    tick();
    tick();
    Reset = 1'b0;

    // Reset state
    check("rst_alive", bus.alive, 4'b1111);
    check("rst_x0", bus.Base_X[0], 200);
    check("rst_y0", bus.Base_Y[0], 100);
    check("rst_x3", bus.Base_X[3], 500);
    check("rst_y3", bus.Base_Y[3], 80);
    check("rst_score", bus.score_inc, 0);
    check("rst_valid", bus.draw_valid, 0);
    tick();
    check("home_pix_valid", bus.draw_valid, 1);
    check("home_pix_sel", bus.draw_sel, 0);
    check("home_pix_expl", bus.draw_explode, 0);

    // Three left scrolls
    bus.direction = 4'b0001;
    frame_evts(3);
    check("left3_x0", bus.Base_X[0], 203);
    check("left3_y0", bus.Base_Y[0], 100);
    check("left3_x1", bus.Base_X[1], 403);

    // Non-one-hot direction holds everything
    bus.direction = 4'b1010;
    frame_evts(2);
    check("hold_x0", bus.Base_X[0], 203);
    check("hold_y1", bus.Base_Y[1], 300);

    // Wrap base 1 to X=0, then right takes it to 639
    bus.direction = 4'b0001;
    frame_evts(237);
    check("wrap_x1_zero", bus.Base_X[1], 0);
    check("wrap_x3", bus.Base_X[3], 100);
    bus.direction = 4'b0010;
    frame_evts(1);
    check("wrap_x1_639", bus.Base_X[1], 639);
    check("right_x0", bus.Base_X[0], 439);
    bus.direction = 4'b1000;
    frame_evts(1);
    bus.direction = 4'b0100;
    frame_evts(2);
    check("updown_y0", bus.Base_Y[0], 99);
    check("updown_y3", bus.Base_Y[3], 79);
    bus.direction = 4'b0000;

    // Hit bases 0 and 1
    bus.DrawX = 10'd449;
    bus.DrawY = 10'd109;
    bus.hit   = 4'b0011;
    tick();
    bus.hit = '0;
    check("hit_score2", bus.score_inc, 2);
    check("hit_alive", bus.alive, 4'b1100);
    tick();
    check("hit_score_clr", bus.score_inc, 0);
    check("expl_valid", bus.draw_valid, 1);
    check("expl_sel", bus.draw_sel, 0);
    check("expl_flag", bus.draw_explode, 1);
    bus.hit = 4'b0001;
    tick();
    bus.hit = '0;
    check("rehit_score0", bus.score_inc, 0);
    check("rehit_alive", bus.alive, 4'b1100);

    // Explode countdown
    frame_evts(15);
    check("expl15_valid", bus.draw_valid, 1);
    check("expl15_flag", bus.draw_explode, 1);
    frame_evts(1);
    check("dead_valid", bus.draw_valid, 0);
    check("dead_sel", bus.draw_sel, 0);
    check("dead_expl", bus.draw_explode, 0);
    check("dead_alive", bus.alive, 4'b1100);
    bus.DrawX = 10'd345;
    bus.DrawY = 10'd360;
    tick();
    check("pix_b2_valid", bus.draw_valid, 1);
    check("pix_b2_sel", bus.draw_sel, 2);
    bus.DrawX = 10'd100;
    bus.DrawY = 10'd100;
    tick();
    check("pix_b3_sel", bus.draw_sel, 3);
    check("pix_b3_expl", bus.draw_explode, 0);

`ifdef BASE_RESPAWN_EN
    frame_evts(119);
    check("resp119_alive", bus.alive, 4'b1100);
    frame_evts(1);
    check("resp_alive", bus.alive, 4'b1111);
    check("resp_x0", bus.Base_X[0], 200);
    check("resp_y0", bus.Base_Y[0], 100);
    check("resp_x1", bus.Base_X[1], 400);
`else
    frame_evts(500);
    check("dead500_alive", bus.alive, 4'b1100);
    check("dead500_x0", bus.Base_X[0], 439);
`endif

    // Fresh start: hit and frame event in the same cycle
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    bus.direction = 4'b0001;
    bus.hit       = 4'b0100;
    frame_clk     = 1'b1;
    tick();
    bus.hit = '0;
    check("same_alive", bus.alive, 4'b1011);
    check("same_score", bus.score_inc, 1);
    check("same_x2", bus.Base_X[2], 101);
    tick();
    tick();
    tick();
    check("level_once_x0", bus.Base_X[0], 201);
    frame_clk = 1'b0;
    tick();
    frame_evts(1);
    check("expl_moves_x2", bus.Base_X[2], 102);

    // Reset mid-EXPLODE
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    check("midrst_alive", bus.alive, 4'b1111);
    check("midrst_x2", bus.Base_X[2], 100);
    check("midrst_y2", bus.Base_Y[2], 350);
    check("midrst_x0", bus.Base_X[0], 200);
    check("midrst_score", bus.score_inc, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
